// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// req/ack backing memory; loads that hit return data in the same cycle.
module dm_cache #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RFILL = 2'd1,
        WTHRU = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              cpu_hit;
    logic              req_hit;
    logic              start_wr;
    logic              start_rd;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign cpu_idx  = cpu_addr[IDX_W-1:0];
    assign cpu_tag  = cpu_addr[ADDR_W-1:IDX_W];
    assign req_idx  = mem_addr[IDX_W-1:0];
    assign req_tag  = mem_addr[ADDR_W-1:IDX_W];
    assign cpu_hit  = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign req_hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    // A store with no byte enables is a no-op, so the read path still applies.
    assign start_wr = cpu_write && (cpu_wen != 4'b0000);
    assign start_rd = cpu_read && !cpu_hit && !start_wr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_wr) begin
                    state_nx = WTHRU;
                end else if (start_rd) begin
                    state_nx = RFILL;
                end else begin
                    state_nx = IDLE;
                end
            end
            RFILL, WTHRU: begin
                if (mem_ack) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = state;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // CPU-side outputs: hit data, fill bypass and pipeline stall
    always_comb begin
        stall     = 1'b0;
        cpu_rdata = 32'h0000_0000;
        if (rst) begin
            stall     = 1'b0;
            cpu_rdata = 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start_wr || start_rd) begin
                        stall = 1'b1;
                    end else if (cpu_read) begin
                        cpu_rdata = data_mem[cpu_idx];
                    end else begin
                        cpu_rdata = 32'h0000_0000;
                    end
                end
                RFILL: begin
                    if (mem_ack) begin
                        cpu_rdata = mem_rdata;
                    end else begin
                        stall = 1'b1;
                    end
                end
                WTHRU: stall = !mem_ack;
                default: stall = 1'b0;
            endcase
        end
    end

    // Backing-memory request register; fields stay frozen until the ack edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wen   <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
        end else if (state == IDLE) begin
            if (start_wr || start_rd) begin
                mem_req   <= 1'b1;
                mem_we    <= start_wr;
                mem_wen   <= start_wr ? cpu_wen : 4'b0000;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end
        end else if (mem_ack) begin
            mem_req <= 1'b0;
        end
    end

    // Valid bits: set on fill completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if ((state == RFILL) && mem_ack) begin
            valid[req_idx] <= 1'b1;
        end
    end

    // Tag/data arrays: fill on read ack, byte-merge on write-through hit
    always_ff @(posedge clk) begin
        if ((state == RFILL) && mem_ack) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= mem_rdata;
        end else if ((state == WTHRU) && mem_ack && req_hit) begin
            data_mem[req_idx] <= merge_bytes(data_mem[req_idx], mem_wdata, mem_wen);
        end
    end
endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed scenarios then random accesses
// compared against an array-based cache and backing-memory model.
module tb_dm_cache;
    localparam int LINES  = 16;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_read;
    logic              cpu_write;
    logic [3:0]        cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    int compared = 0;
    int mismatched = 0;

    bit          m_valid [LINES];
    int          m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] bmem    [int];

    dm_cache #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int a);
        if (bmem.exists(a)) return bmem[a];
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // One CPU access; dly = number of req cycles before the ack cycle.
    task automatic access(input bit rd, input bit wr, input logic [3:0] wen,
                          input int addr, input logic [31:0] wdata, input int dly,
                          output logic [31:0] got);
        int          idx;
        int          tg;
        bit          hit;
        bit          is_wr;
        logic [31:0] exp;
        idx   = addr % LINES;
        tg    = addr / LINES;
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        is_wr = wr && (wen != 4'd0);
        exp   = mem_rd(addr);
        @(negedge clk);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_wen   = wen;
        cpu_addr  = ADDR_W'(addr);
        cpu_wdata = wdata;
        mem_ack   = 1'b0;
        #1;
        got = cpu_rdata;
        check("detect_req_low", mem_req, 32'd0);
        if (is_wr || (rd && !hit)) begin
            check("detect_stall", stall, 32'd1);
            check("detect_rdata_zero", cpu_rdata, 32'd0);
            for (int c = 0; c <= dly; c++) begin
                @(negedge clk);
                mem_ack   = (c == dly);
                mem_rdata = (c == dly && !is_wr) ? exp : $urandom;
                #1;
                check("req_high", mem_req, 32'd1);
                check("req_we", mem_we, 32'(is_wr));
                check("req_addr", 32'(mem_addr), 32'(addr));
                if (is_wr) begin
                    check("req_wen", 32'(mem_wen), 32'(wen));
                    check("req_wdata", mem_wdata, wdata);
                end
                check("busy_stall", stall, 32'(c != dly));
                if (c == dly && !is_wr) begin
                    got = cpu_rdata;
                    check("fill_rdata", cpu_rdata, exp);
                end else begin
                    check("busy_rdata_zero", cpu_rdata, 32'd0);
                end
            end
            if (is_wr) begin
                bmem[addr] = merge(exp, wdata, wen);
                if (hit) m_data[idx] = merge(m_data[idx], wdata, wen);
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = exp;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
            #1;
            check("req_dropped", mem_req, 32'd0);
            check("after_stall", stall, 32'd0);
        end else begin
            check("nostall", stall, 32'd0);
            check("hit_rdata", cpu_rdata, rd ? m_data[idx] : 32'd0);
        end
    endtask

    initial begin
        logic [31:0] got;
        rst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_wen = 4'd0;
        cpu_addr = 14'h0010; cpu_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        clear_model();
        #7;
        check("rst_stall", stall, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_req", mem_req, 32'd0);
        check("rst_we", mem_we, 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0; cpu_read = 1'b0;

        // cold miss then hit
        bmem[16] = 32'hDEAD_BEEF;
        access(1'b1, 1'b0, 4'd0, 16, 32'd0, 0, got);
        check("cold_fill", got, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 4'd0, 16, 32'd0, 0, got);
        check("rehit", got, 32'hDEAD_BEEF);

        // write-hit byte merge
        bmem[5] = 32'h1122_3344;
        access(1'b1, 1'b0, 4'd0, 5, 32'd0, 1, got);
        access(1'b0, 1'b1, 4'b0010, 5, 32'h0000_AA00, 1, got);
        access(1'b1, 1'b0, 4'd0, 5, 32'd0, 0, got);
        check("merged_hit", got, 32'h1122_AA44);

        // write miss without allocation
        access(1'b0, 1'b1, 4'hF, 32, 32'h1234_5678, 2, got);
        access(1'b1, 1'b0, 4'd0, 32, 32'd0, 0, got);
        check("write_miss_then_fill", got, 32'h1234_5678);

        // index conflict
        bmem[1] = 32'h0000_000A; bmem[17] = 32'h0000_000B;
        access(1'b1, 1'b0, 4'd0, 1, 32'd0, 0, got);
        access(1'b1, 1'b0, 4'd0, 17, 32'd0, 0, got);
        check("conflict_b", got, 32'h0000_000B);
        access(1'b1, 1'b0, 4'd0, 1, 32'd0, 1, got);
        check("conflict_a_refill", got, 32'h0000_000A);

        // delayed ack, then a stray ack in IDLE
        access(1'b1, 1'b0, 4'd0, 37, 32'd0, 5, got);
        @(negedge clk); mem_ack = 1'b1; #1;
        check("idle_ack_stall", stall, 32'd0);
        @(negedge clk); mem_ack = 1'b0; #1;
        check("idle_ack_noreq", mem_req, 32'd0);
        access(1'b1, 1'b0, 4'd0, 37, 32'd0, 0, got);
        check("hit_after_idle_ack", got, 32'hC0DE_0025);

        // no-op store and write-priority
        access(1'b0, 1'b1, 4'd0, 5, 32'hFFFF_FFFF, 0, got);
        access(1'b1, 1'b1, 4'b1000, 5, 32'h7700_0000, 0, got);
        access(1'b1, 1'b0, 4'd0, 5, 32'd0, 0, got);
        check("priority_write", got, 32'h7722_AA44);

        // reset in the middle of a fill
        @(negedge clk); cpu_read = 1'b1; cpu_addr = 14'h0033; #1;
        check("midfill_detect", stall, 32'd1);
        @(negedge clk); #1;
        check("midfill_req", mem_req, 32'd1);
        rst = 1'b1; #1;
        check("midfill_rst_req", mem_req, 32'd0);
        check("midfill_rst_stall", stall, 32'd0);
        check("midfill_rst_rdata", cpu_rdata, 32'd0);
        clear_model();
        @(negedge clk); rst = 1'b0; cpu_read = 1'b0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk); mem_ack = 1'b0; #1;
        check("late_ack_ignored", mem_req, 32'd0);
        access(1'b1, 1'b0, 4'd0, 5, 32'd0, 0, got);
        access(1'b1, 1'b0, 4'd0, 51, 32'd0, 0, got);
        check("abandoned_line_refetch", got, 32'hC0DE_0033);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 3);
            access((op == 0) || (op == 1) || (op == 3), (op >= 2),
                   4'($urandom_range(0, 15)), $urandom_range(0, 47),
                   $urandom, $urandom_range(0, 3), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
